// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// No logic, no latency; not subject to backpressure.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        HALT = 2'd3
    } fetchState_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] alignPC(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle between the sequencer (master) and fetch/decode (slave).
// Pure wiring, zero latency; stall is the only backpressure and flows slave to master.
interface fetch_ctrl_if #(parameter int CNT_W = 32);

    logic [31:0]      pc;
    logic             stall;
    logic             br_valid;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             xr_valid;
    logic [31:0]      xr_target;
    logic             halt_req;
    logic [31:0]      nextPC;
    logic             pcWE;
    logic             ifid_en;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        input  pc, stall, br_valid, br_taken, br_target, xr_valid, xr_target, halt_req,
        output nextPC, pcWE, ifid_en, halted, fetch_cnt
    );

    modport slave (
        output pc, stall, br_valid, br_taken, br_target, xr_valid, xr_target, halt_req,
        input  nextPC, pcWE, ifid_en, halted, fetch_cnt
    );

endinterface

// File: rtl/fetch_ctrl_pc_sel.sv
// Priority mux for the next fetch address, word-aligned; purely combinational.
// Ignores stall: the caller qualifies the result with its own write enable.
module pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        reset,
    input  fetchState_t state,
    input  logic [31:0] pendTgt,
    input  logic [31:0] pc,
    input  logic        xr_valid,
    input  logic [31:0] xr_target,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] nextPC
);

    logic [31:0] rawPC;

    // A fresh external redirect beats a pending one, which beats a branch.
    always_comb begin
        rawPC = pc + PC_STEP;
        if (!reset || state == BOOT) begin
            rawPC = RESET_PC;
        end else if (xr_valid) begin
            rawPC = xr_target;
        end else if (state == PEND) begin
            rawPC = pendTgt;
        end else if (br_valid && br_taken) begin
            rawPC = br_target;
        end
        nextPC = alignPC(rawPC);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC write enable, IF/ID enable, redirect/halt arbitration, fetch counter.
// nextPC/pcWE/ifid_en are same-cycle combinational; stall freezes fetch and parks redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input logic        clk,
    input logic        reset,
    fetch_ctrl_if.master bus
);

    fetchState_t      state;
    logic [31:0]      pendTgt;
    logic             haltedQ;
    logic [CNT_W-1:0] cnt;
    logic             advance;

    assign advance       = reset && !bus.stall && (state == RUN || state == PEND);
    assign bus.pcWE      = advance;
    assign bus.ifid_en   = advance;
    assign bus.halted    = haltedQ && reset;
    assign bus.fetch_cnt = cnt;

    pc_sel #(.RESET_PC(RESET_PC)) u_pc_sel (
        .reset     (reset),
        .state     (state),
        .pendTgt   (pendTgt),
        .pc        (bus.pc),
        .xr_valid  (bus.xr_valid),
        .xr_target (bus.xr_target),
        .br_valid  (bus.br_valid),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .nextPC    (bus.nextPC)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= BOOT;
            pendTgt <= '0;
            haltedQ <= 1'b0;
            cnt     <= '0;
        end else begin
            if (advance && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (bus.stall) begin
                        if (bus.xr_valid) begin
                            pendTgt <= bus.xr_target;
                            state   <= PEND;
                        end
                    end else if (bus.halt_req) begin
                        state   <= HALT;
                        haltedQ <= 1'b1;
                    end
                end
                PEND: begin
                    if (bus.xr_valid) begin
                        pendTgt <= bus.xr_target;
                    end
                    // The release cycle consumes the pending target and still honours halt.
                    if (!bus.stall) begin
                        if (bus.halt_req) begin
                            state   <= HALT;
                            haltedQ <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage of the 5-stage MIPS pipeline. Computes `nextPC` and `pcWE` for the fetch unit and the enable for the IF/ID register. Arbitrates between sequential fetch, D-stage branch/jump redirects (delay-slot semantics), late external redirects that may arrive during a stall, and a terminal halt. Keeps a retired-fetch counter for performance checks.

## Interface
- `RESET_PC`, 32'h00003000, PC value loaded on reset and driven on `nextPC` during reset.
- `CNT_W`, 32, width of the fetch counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; asserted when 0, sampled on `clk` rising edge.
- `pc`  in  32  current PC from the fetch unit.
- `stall`  in  1  hazard-unit stall; freezes F and D.
- `br_valid`  in  1  D stage holds a control-transfer instruction resolved this cycle.
- `br_taken`  in  1  the resolved transfer is taken; meaningful only with `br_valid`.
- `br_target`  in  32  taken target.
- `xr_valid`  in  1  one-cycle external redirect request from a later stage.
- `xr_target`  in  32  external redirect target.
- `halt_req`  in  1  D stage decodes the halt instruction.
- `nextPC`  out  32  value the fetch unit loads when `pcWE`=1.
- `pcWE`  out  1  PC write enable.
- `ifid_en`  out  1  IF/ID pipeline-register enable.
- `halted`  out  1  controller is in HALT.
- `fetch_cnt`  out  CNT_W  number of cycles with `pcWE`=1 since reset.

## Operation
- States: BOOT, RUN, PEND, HALT.
- Reset (`reset`=0 at an edge): state→BOOT, pending register cleared, `fetch_cnt`→0.
  - While `reset`=0: `nextPC`=RESET_PC, `pcWE`=0, `ifid_en`=0, `halted`=0.
- BOOT: lasts exactly one cycle. `pcWE`=0, `ifid_en`=0, `nextPC`=RESET_PC. Next state is RUN.
- RUN, `nextPC` priority:
  1. `xr_valid` → `xr_target`.
  2. `br_valid & br_taken` → `br_target`.
  3. otherwise `pc`+4.
- RUN, `stall`=1:
  - `pcWE`=0, `ifid_en`=0.
  - `br_valid` is ignored; the hazard unit re-presents the branch.
  - If `xr_valid`=1, latch `xr_target` into the pending register and go to PEND.
- RUN, `stall`=0: `pcWE`=1, `ifid_en`=1.
- PEND:
  - While `stall`=1: hold.
  - A new `xr_valid` overwrites the pending target (last one wins).
  - On the first cycle with `stall`=0: `nextPC`=pending target, `pcWE`=1, `ifid_en`=1, then go to RUN. The pending target overrides any `br_valid` in that cycle.
- Halt:
  - `halt_req`=1 with `stall`=0 in RUN or PEND → HALT at the next edge.
  - That cycle still advances normally (the delay slot is fetched).
  - HALT: `pcWE`=0, `ifid_en`=0, `halted`=1. All inputs are ignored until reset.
- Simultaneous `xr_valid` and `halt_req` with `stall`=0: the redirect is applied and HALT is still entered.
- Width rules:
  - `pc`+4 wraps modulo 2^32.
  - Every target loaded into `nextPC` has bits [1:0] forced to 0.
  - `fetch_cnt` increments when `pcWE`=1 and saturates at all-ones.

## Timing
- `nextPC`, `pcWE` and `ifid_en` are combinational from the state, the pending register and the inputs. There is no added latency; the fetch unit registers the PC on the same edge.
- `halted` and `fetch_cnt` are registered and update on the edge after the event.
- Branch latency: with `br_valid`/`br_taken` at cycle t, the target is in PC at t+1. The instruction fetched at t is the delay slot and is not squashed.
- An `xr_valid` arriving during a stall takes effect on the first non-stall cycle; the fetch unit holds the target from the next edge.

## Structure
- Shared package `fetch_pkg`:
  - the state encoding (BOOT, RUN, PEND, HALT as a 2-bit enum);
  - `RESET_PC_DEFAULT`;
  - the `PC_STEP`=4 constant.
- Sub-module `pc_sel`: a purely combinational priority mux that produces the aligned `nextPC` from the state and the inputs.
- The FSM, the pending register and the counter live in `fetch_ctrl`.

## Test plan
- Reset held 3 cycles, then released → BOOT for 1 cycle with `pcWE`=0; RUN from the next cycle, `nextPC`=0x3004 with `pc`=0x3000; `fetch_cnt`=1 one cycle later.
- `br_valid`=`br_taken`=1, `br_target`=0x3022, `stall`=0 → `nextPC`=0x3020, `pcWE`=1. With `br_taken`=0 → `nextPC`=`pc`+4.
- `stall` held 3 cycles with `xr_valid` pulsed (target 0x4000) in stall cycle 1 → `pcWE`=0 for all 3 cycles; first non-stall cycle gives `nextPC`=0x4000, overriding a concurrent branch to 0x5000.
- Two `xr_valid` pulses (0x4000, then 0x4100) during one stall → the release cycle applies 0x4100.
- `halt_req` with `stall`=0 → that cycle `pcWE`=1; afterwards `halted`=1 and `pcWE`=0 indefinitely despite branch/`xr` stimulus; reset returns to BOOT.
- `pc`=0xFFFFFFFC, no redirect → `nextPC`=0x00000000. `fetch_cnt` preloaded near saturation holds at all-ones.
